// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, write-to-read bypass and a
// per-register pending-write scoreboard. Define REGFILE_DEBUG_PORT_EN for a bypass-free debug read port.
module regfile_sb #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  output logic          busy1,
  output logic          busy2,
  input  logic          iss_valid,
  input  logic [AW-1:0] iss_addr,
  output logic          iss_ready,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
`ifdef REGFILE_DEBUG_PORT_EN
  input  logic [AW-1:0] dbg_sel,
  output logic [DW-1:0] dbg_data,
  output logic          dbg_busy,
`endif
  output logic          err
);

  localparam int DEPTH = 1 << AW;

  logic [DEPTH-1:0][DW-1:0] rf;
  logic [DEPTH-1:0][CW-1:0] cnt;
  logic [DEPTH-1:0]         inc, dec;
  logic                     wnz, ret, alloc;

  always_comb begin
    wnz       = (wa != '0);
    ret       = we && wnz && (cnt[wa] != '0);
    // A full counter can still accept an allocation when the same register retires this cycle.
    iss_ready = (iss_addr == '0) || (cnt[iss_addr] != '1) || (ret && (wa == iss_addr));
    alloc     = iss_valid && iss_ready && (iss_addr != '0);
    inc       = '0;
    dec       = '0;
    if (alloc) inc[iss_addr] = 1'b1;
    if (ret)   dec[wa]       = 1'b1;
  end

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (ra1 != '0) rd1 = (we && wa == ra1) ? wd : rf[ra1];
    if (ra2 != '0) rd2 = (we && wa == ra2) ? wd : rf[ra2];
  end

  // Busy reflects the count after this cycle's retirement, so a last retire reads as free + bypassed.
  assign busy1 = (ra1 != '0) && ((cnt[ra1] - CW'(ret && (wa == ra1))) != '0);
  assign busy2 = (ra2 != '0) && ((cnt[ra2] - CW'(ret && (wa == ra2))) != '0);

`ifdef REGFILE_DEBUG_PORT_EN
  assign dbg_data = (dbg_sel == '0) ? '0 : rf[dbg_sel];
  assign dbg_busy = (cnt[dbg_sel] != '0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf  <= '0;
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (we && wnz) rf[wa] <= wd;
      if (we && wnz && (cnt[wa] == '0)) err <= 1'b1;
      for (int r = 1; r < DEPTH; r++) begin
        if (inc[r] && !dec[r])      cnt[r] <= cnt[r] + CW'(1);
        else if (dec[r] && !inc[r]) cnt[r] <= cnt[r] - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb: reset, bypass, r0, scoreboard limits, err.
module tb_regfile_sb;
  localparam int DW = 32, AW = 5, CW = 2;

  logic          clk = 1'b0, rst_n;
  logic [AW-1:0] ra1, ra2, iss_addr, wa;
  logic [DW-1:0] rd1, rd2, wd;
  logic          busy1, busy2, iss_valid, iss_ready, we, err;
`ifdef REGFILE_DEBUG_PORT_EN
  logic [AW-1:0] dbg_sel;
  logic [DW-1:0] dbg_data;
  logic          dbg_busy;
`endif

  int n_chk = 0, n_fail = 0;

  regfile_sb #(.DW(DW), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .busy1(busy1), .busy2(busy2), .iss_valid(iss_valid), .iss_addr(iss_addr),
    .iss_ready(iss_ready), .we(we), .wa(wa), .wd(wd),
`ifdef REGFILE_DEBUG_PORT_EN
    .dbg_sel(dbg_sel), .dbg_data(dbg_data), .dbg_busy(dbg_busy),
`endif
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change there, checks follow at +1.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef REGFILE_DEBUG_PORT_EN
    dbg_sel = '0;
`endif
    rst_n = 1'b0; ra1 = '0; ra2 = '0; iss_valid = 1'b0; iss_addr = '0;
    we = 1'b0; wa = '0; wd = '0;
    #3;
    chk("err_in_reset", DW'(err), 0);
    #9 rst_n = 1'b1;
    step();

    // Clean state after reset across every address.
    for (int i = 0; i < 32; i++) begin
      ra1 = AW'(i); ra2 = AW'(31 - i);
      #1;
      chk($sformatf("rst_rd1_%0d", i), rd1, 0);
      chk($sformatf("rst_rd2_%0d", i), rd2, 0);
      chk($sformatf("rst_busy1_%0d", i), DW'(busy1), 0);
      chk($sformatf("rst_busy2_%0d", i), DW'(busy2), 0);
    end
    chk("rst_err", DW'(err), 0);

    // Allocate r5, then write it back with bypass and storage read.
    iss_valid = 1'b1; iss_addr = 5'd5; ra1 = 5'd5;
    #1 chk("r5_iss_ready", DW'(iss_ready), 1);
    step();
    iss_valid = 1'b0;
    #1 chk("r5_busy", DW'(busy1), 1);
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
    #1 chk("r5_bypass", rd1, 32'hDEADBEEF);
    chk("r5_busy_last_ret", DW'(busy1), 0);
    step();
    we = 1'b0; ra2 = 5'd5;
    #1 chk("r5_stored_rd1", rd1, 32'hDEADBEEF);
    chk("r5_stored_rd2", rd2, 32'hDEADBEEF);
    chk("r5_err", DW'(err), 0);

    // r0 ignores writes and never flags err.
    we = 1'b1; wa = 5'd0; wd = 32'h12345678; ra1 = 5'd0;
    #1 chk("r0_bypass_blocked", rd1, 0);
    step();
    we = 1'b0;
    #1 chk("r0_rd", rd1, 0);
    chk("r0_err", DW'(err), 0);
    iss_valid = 1'b1; iss_addr = 5'd0;
    #1 chk("r0_iss_ready", DW'(iss_ready), 1);
    step();
    iss_valid = 1'b0; ra1 = 5'd0;
    #1 chk("r0_busy", DW'(busy1), 0);

    // Fill r7 to the counter limit.
    iss_valid = 1'b1; iss_addr = 5'd7; ra1 = 5'd7;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("r7_iss_ready_%0d", i), DW'(iss_ready), 1);
      step();
    end
    #1 chk("r7_busy_full", DW'(busy1), 1);
    chk("r7_iss_full", DW'(iss_ready), 0);
    we = 1'b1; wa = 5'd7; wd = 32'hA5A5A5A5;
    #1 chk("r7_iss_ready_with_ret", DW'(iss_ready), 1);
    chk("r7_busy_alloc_ret", DW'(busy1), 1);
    chk("r7_bypass", rd1, 32'hA5A5A5A5);
    step();
    // Alloc and retire cancelled, so the counter is still full.
    we = 1'b0;
    #1 chk("r7_still_full", DW'(iss_ready), 0);
    iss_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      we = 1'b1; wa = 5'd7; wd = 32'h1000 + DW'(i);
      #1 chk($sformatf("r7_ret_busy_%0d", i), DW'(busy1), (i == 2) ? 0 : 1);
      chk($sformatf("r7_ret_rd_%0d", i), rd1, 32'h1000 + DW'(i));
      step();
    end
    we = 1'b0;
    #1 chk("r7_drained_busy", DW'(busy1), 0);
    chk("r7_drained_rd", rd1, 32'h1002);
    chk("r7_err", DW'(err), 0);

    // Unallocated writeback: data lands, err latches; r11 left pending.
    iss_valid = 1'b1; iss_addr = 5'd11;
    we = 1'b1; wa = 5'd9; wd = 32'hCAFEF00D; ra1 = 5'd9; ra2 = 5'd11;
    #1 chk("r9_bypass", rd1, 32'hCAFEF00D);
    chk("r9_err_pre", DW'(err), 0);
    step();
    we = 1'b0; iss_valid = 1'b0;
    #1 chk("r9_stored", rd1, 32'hCAFEF00D);
    chk("r9_err_set", DW'(err), 1);
    chk("r11_busy", DW'(busy2), 1);
    chk("r9_busy", DW'(busy1), 0);
    step();
    #1 chk("r9_err_sticky", DW'(err), 1);

    // Asynchronous reset between edges clears everything immediately.
    rst_n = 1'b0;
    #1 chk("async_err", DW'(err), 0);
    chk("async_r9", rd1, 0);
    chk("async_r11_busy", DW'(busy2), 0);
    ra2 = 5'd5;
    #1 chk("async_r5", rd2, 0);
    rst_n = 1'b1;
    step();
    ra1 = 5'd7; ra2 = 5'd11;
    #1 chk("post_rst_r7", rd1, 0);
    chk("post_rst_r11_busy", DW'(busy2), 0);
    chk("post_rst_err", DW'(err), 0);
    iss_valid = 1'b1; iss_addr = 5'd7;
    #1 chk("post_rst_iss_ready", DW'(iss_ready), 1);
    iss_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
